chip8_memory: RTL

- Byte-wide 4 KiB memory responder serving the CHIP-8 CPU's mem_read/mem_write interface. It is the target end of the CPU's fetch/load/store bus.
- After reset it copies the 80-byte hex font into 0x000-0x04F.
- A secondary loader port writes program images, normally from 0x200, while the CPU is idle.
- Sits between cpu and the top-level program loader.

---
 rtl/chip8_pkg.sv | 39 +++
 rtl/chip8_font_rom.sv | 19 +
 rtl/chip8_memory.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/chip8_pkg.sv
// Purpose : shared constants, state encoding and hex font table for the CHIP-8 memory.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: FONT_BASE / FONT_BYTES / PROGRAM_BASE, the responder state enum and
//           the 80-byte glyph table (glyphs 0-F, five rows each, MSB = left pixel).
package chip8_pkg;

    localparam logic [11:0] FONT_BASE    = 12'h000;
    localparam int          FONT_BYTES   = 80;
    localparam logic [11:0] PROGRAM_BASE = 12'h200;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        WAIT = 2'd2,
        ACK  = 2'd3
    } mem_state_t;

    // Entry 0 is the leftmost byte: glyph g occupies entries 5*g .. 5*g+4.
    localparam logic [0:FONT_BYTES-1][7:0] FONT_TABLE = {
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  // 0
        8'h20, 8'h60, 8'h20, 8'h20, 8'h70,  // 1
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  // 2
        8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,  // 3
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  // 4
        8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,  // 5
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  // 6
        8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,  // 7
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  // 8
        8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,  // 9
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  // A
        8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,  // B
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  // C
        8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,  // D
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  // E
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80   // F
    };

endpackage

// File: rtl/chip8_font_rom.sv
// Purpose : combinational glyph lookup feeding the post-reset font copy.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; index beyond the table returns 0.
// Ports   : index (7-bit byte index into the font), glyph (8-bit row bits).
module chip8_font_rom
    import chip8_pkg::*;
(
    input  logic [6:0] index,
    output logic [7:0] glyph
);

    always_comb begin
        glyph = 8'h00;
        if (index < 7'(FONT_BYTES)) begin
            glyph = FONT_TABLE[index];
        end
    end

endmodule

// File: rtl/chip8_memory.sv
// Purpose : 4 KiB byte memory answering CPU fetch/load/store; copies the hex font after reset.
// Latency : read ack READ_LATENCY cycles after acceptance; writes commit on the strobe edge.
// Backpressure: loader stalled (load_ready=0) during font copy or when the CPU writes that cycle.
// Ports   : clk/rst_n; CPU read (mem_read, mem_read_addr -> mem_read_data, mem_read_ack);
//           CPU write (mem_write, mem_write_addr, mem_write_data);
//           loader (load_valid, load_addr, load_data -> load_ready); init_done status.
module chip8_memory
    import chip8_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int MEM_BYTES    = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic [11:0] mem_read_addr,
    output logic [7:0]  mem_read_data,
    output logic        mem_read_ack,
    input  logic        mem_write,
    input  logic [11:0] mem_write_addr,
    input  logic [7:0]  mem_write_data,
    input  logic        load_valid,
    input  logic [11:0] load_addr,
    input  logic [7:0]  load_data,
    output logic        load_ready,
    output logic        init_done
);

    // WAIT lasts READ_LATENCY-1 cycles: the counter is loaded with that minus one
    // and WAIT exits on the cycle it reads zero.
    localparam logic [1:0] WAIT_LOAD = 2'((READ_LATENCY > 1) ? (READ_LATENCY - 2) : 0);

    logic [7:0]  mem [MEM_BYTES];

    mem_state_t  state;
    logic [6:0]  init_cnt;
    logic [1:0]  wait_cnt;
    logic [11:0] addr_q;
    logic [11:0] last_addr;
    logic        rearm;
    logic        ack_q;
    logic [7:0]  rd_dat;
    logic [7:0]  font_dat;
    logic        accept;

    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_dat;

    chip8_font_rom u_font_rom (
        .index (init_cnt),
        .glyph (font_dat)
    );

    assign load_ready = init_done & ~mem_write;
    assign accept     = (state == IDLE) && mem_read && rearm;

    // Single write port: font copy, then CPU store, then loader.
    // A CPU store arriving during the font copy is simply lost.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = 12'h000;
        wr_dat  = 8'h00;
        if (state == INIT) begin
            wr_en   = 1'b1;
            wr_addr = FONT_BASE + {5'b0, init_cnt};
            wr_dat  = font_dat;
        end else if (mem_write) begin
            wr_en   = 1'b1;
            wr_addr = mem_write_addr;
            wr_dat  = mem_write_data;
        end else if (load_valid && load_ready) begin
            wr_en   = 1'b1;
            wr_addr = load_addr;
            wr_dat  = load_data;
        end
    end

    // Array is deliberately outside reset so program bytes survive a reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Free-running synchronous read of the latched address. The value captured on
    // the edge that raises ack is what the CPU sees, so a store on that same edge
    // is not reflected (read-old), while earlier stores are.
    always_ff @(posedge clk) begin
        rd_dat <= mem[addr_q];
    end

    assign mem_read_ack  = ack_q;
    assign mem_read_data = ack_q ? rd_dat : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            init_cnt  <= 7'd0;
            wait_cnt  <= 2'd0;
            addr_q    <= 12'h000;
            last_addr <= 12'h000;
            rearm     <= 1'b1;
            ack_q     <= 1'b0;
            init_done <= 1'b0;
        end else begin
            ack_q <= 1'b0;

            case (state)
                INIT: begin
                    if (init_cnt == 7'(FONT_BYTES - 1)) begin
                        state     <= IDLE;
                        init_done <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + 7'd1;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        addr_q    <= mem_read_addr;
                        last_addr <= mem_read_addr;
                        if (READ_LATENCY == 1) begin
                            state <= ACK;
                        end else begin
                            wait_cnt <= WAIT_LOAD;
                            state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state <= ACK;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                ACK: begin
                    ack_q <= 1'b1;
                    state <= IDLE;
                end
                default: state <= INIT;
            endcase

            // A held request is only served again once the requester either drops
            // mem_read or moves to a new address; this prevents double acks.
            if (state == ACK) begin
                rearm <= 1'b0;
            end else if (!mem_read || (mem_read_addr != last_addr)) begin
                rearm <= 1'b1;
            end
        end
    end

endmodule
